// File: rtl/rej_sampler12.sv
// Kyber uniform rejection sampler: splits a 32-bit byte stream into 12-bit
// candidates, forwards those below Q, and stops after NCOEF accepted values.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | buffering bytes and evaluating candidates
// DONE  | one-cycle done pulse, then back to IDLE
module rej_sampler12 #(
  parameter int IWID  = 12,
  parameter int Q     = 3329,
  parameter int NCOEF = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     din,
  input  logic            din_vld,
  output logic            din_rdy,
  output logic [IWID-1:0] dout,
  output logic            dout_vld,
  input  logic            dout_rdy,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(NCOEF + 1);
  localparam logic [IWID-1:0] QV   = IWID'(Q);
  localparam logic [CW-1:0]   NMAX = CW'(NCOEF);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [55:0]     bbuf, buf_sh, buf_nx;
  logic [2:0]      bcnt, bcnt_sh, bcnt_nx;
  logic            phase;
  logic [CW-1:0]   count;
  logic [IWID-1:0] cand;
  logic            stop, eval, accept, take, drop;

  always_comb begin
    stop    = (count == NMAX);
    cand    = phase ? {bbuf[23:16], bbuf[15:12]} : {bbuf[11:8], bbuf[7:0]};
    din_rdy = (state == RUN) && (bcnt <= 3'd3) && !stop;
    eval    = (state == RUN) && (bcnt >= 3'd3) && (!dout_vld || dout_rdy) && !stop;
    accept  = eval && (cand < QV);
    take    = din_vld && din_rdy;
    drop    = eval && phase;
    // Shift out the consumed triple first so the new word lands right above what remains.
    buf_sh  = drop ? {24'd0, bbuf[55:24]} : bbuf;
    bcnt_sh = drop ? bcnt - 3'd3 : bcnt;
    buf_nx  = buf_sh;
    bcnt_nx = bcnt_sh;
    if (take) begin
      buf_nx  = buf_sh | ({24'd0, din} << {bcnt_sh, 3'b000});
      bcnt_nx = bcnt_sh + 3'd4;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        // With all NCOEF loaded, the word in dout is the last coefficient.
        if (stop && dout_vld && dout_rdy) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bbuf     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
      count    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        bbuf  <= '0;
        bcnt  <= '0;
        phase <= 1'b0;
        count <= '0;
      end else begin
        bbuf <= buf_nx;
        bcnt <= bcnt_nx;
        if (eval)   phase <= ~phase;
        if (accept) count <= count + CW'(1);
      end
      if (accept) begin
        dout     <= cand;
        dout_vld <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule
